converge_ctrl_rr: RTL and testbench
===================================

Name: converge_ctrl_rr

Overview:
Parametrised successor to the leaf-side stream converger. It merges two sources onto one `stream_out` packet stream toward the BFT:
- freespace-update packets captured from N input ports, buffered in an internal update FIFO with strict priority;
- data packets from M output-port queues, served round-robin, skipping empty queues.

Changes from the previous generation:
- channel counts, FIFO depth and widths are fully generic;
- empty output ports are skipped instead of polled blindly;
- an explicit one-deep hold register makes `resend` stalls lossless.

Parameters:
- PACKET_BITS, 97, packet width; bit PACKET_BITS-1 is the valid bit.
- NUM_IN_PORTS, 7, input ports supplying freespace updates (1..32).
- NUM_OUT_PORTS, 7, output-port queues to converge (1..32).
- UPD_FIFO_DEPTH, 16, update FIFO depth (power of 2, at least 2).
- UPD_BURST_MAX, 4, consecutive update grants before a forced data grant (used only with CONVERGE_FAIR_EN).

Ports:
- clk_bft  in  1  single clock.
- reset_bft  in  1  synchronous, active-high reset.
- freespace_update  in  NUM_IN_PORTS  per-port update strobe level; a rising edge requests capture.
- packet_from_input_ports  in  PACKET_BITS*NUM_IN_PORTS  update packet per input port; slice i = [PACKET_BITS*(i+1)-1 : PACKET_BITS*i].
- packet_from_output_ports  in  PACKET_BITS*NUM_OUT_PORTS  queue read data per output port, 1-cycle read latency.
- empty  in  NUM_OUT_PORTS  queue-empty flags.
- resend  in  1  downstream stall/replay request.
- outport_sel  out  NUM_OUT_PORTS  one-hot queue read strobe, combinational.
- stream_out  out  PACKET_BITS  converged packet, registered.
- upd_drop  out  1  sticky flag: a pending update was overwritten before it was drained.

Behaviour:
- Reset (synchronous): clears stream_out, hold register, all pending slots, both RR pointers, update FIFO, upd_drop, resend_d and the edge-detect history.
  - Edge history resets to 0, so a freespace_update bit held high through reset counts as a rising edge on the first cycle after reset.
  - outport_sel = 0 throughout reset.
- Capture: a rising edge on bit i latches slice i into slot i.
  - The slot is pending iff the latched MSB = 1.
  - An edge on an already-pending slot overwrites the slot and sets upd_drop.
- Slot drain: each cycle, take the first pending slot at or after in_ptr (cyclic).
  - If the FIFO is not full: write that slot to the FIFO, clear the slot, set in_ptr = winner+1, wrapping from NUM_IN_PORTS-1 to 0.
  - If the FIFO is full: no write; slots and in_ptr hold.
  - Capture and drain on the same slot in the same cycle: capture wins; the slot stays pending with the new data, and the drained old data is still written.
- Stall: stall = resend | resend_d, where resend_d is resend registered one cycle. While stall = 1, no FIFO read and outport_sel = 0.
- Grant rules when not stalled:
  - FIFO non-empty: read the FIFO; outport_sel = 0.
  - FIFO empty and some empty[j] = 0: outport_sel has a single bit set for the first non-empty j at or after out_ptr (cyclic); out_ptr = j+1, wrapping from NUM_OUT_PORTS-1 to 0.
  - Otherwise: no grant.
- Latency: a grant in cycle N puts the packet on stream_out in cycle N+2. A cycle with no grant yields stream_out = 0 two cycles later (bubble).
- Resend, normal flow (resend=0, resend_d=0): stream_out <= arriving data, or 0 if none.
- Resend, first stall cycle (resend=1, resend_d=0): stream_out holds; hold register <= arriving data, or 0 if none.
- Resend, continued stall (resend=1, resend_d=1): stream_out and hold register both hold.
- Resend, release (resend=0, resend_d=1): stream_out <= hold register; hold register <= 0. Grants resume the following cycle.
- Pointer behaviour: pointers advance only on grants. Empty inputs never stall or skew the rotation.
- Reset mid-stall or mid-flight: in-flight and held packets are discarded; stream_out = 0 the cycle after reset.

Optional Feature:
- Macro: CONVERGE_FAIR_EN.
- Defined: a counter tracks consecutive FIFO grants. When it reaches UPD_BURST_MAX and some output queue is non-empty, the next non-stalled grant goes to the output RR and the counter clears. The counter also clears on any data grant, and when the FIFO is empty.
- Undefined: the update FIFO has absolute priority, as specified above, and the counter logic is absent.

Test Plan:
- Three queues non-empty (ports 0, 2, 5), no updates → outport_sel sequence 0x01, 0x04, 0x20, 0x01; stream_out matches each port's data 2 cycles after each grant.
- Rising edges on in-ports 1 and 3 in the same cycle, MSB=1, while queues are busy → both packets on stream_out before any further data packet, order 1 then 3; outport_sel = 0 during the FIFO reads.
- Captured packet with MSB=0 → nothing written to the FIFO; queue service is uninterrupted.
- Second edge on in-port 4 before its slot drains (FIFO held full by stall) → upd_drop = 1; only the second packet appears.
- resend high for 5 cycles with a grant in the cycle before → stream_out frozen; on release the held packet appears once, then a bubble; no packet lost or duplicated.
- Full FIFO (16 entries) plus 7 pending slots → no writes while full, no loss; 23 update packets emitted in order. With CONVERGE_FAIR_EN and UPD_BURST_MAX=4: one data packet after every 4 updates.

Source files
------------

// File: rtl/converge_ctrl_rr.sv
// converge_ctrl_rr
//   Merges freespace-update packets (captured from NUM_IN_PORTS input ports and
//   queued in an internal update FIFO) with data packets read from
//   NUM_OUT_PORTS output-port queues onto a single registered packet stream.
//   The update FIFO has priority over data. Data queues are served round-robin,
//   and empty queues are skipped. A one-deep hold register keeps resend stalls
//   lossless.
//
//   Optional feature macro: CONVERGE_FAIR_EN
//     When defined, after UPD_BURST_MAX consecutive FIFO grants one grant is
//     forced to the data round-robin if any queue has data.
//
// Ports
//   clk_bft                  : clock
//   reset_bft                : synchronous active-high reset
//   freespace_update         : per-input-port update strobe level (rising edge = capture)
//   packet_from_input_ports  : update packet per input port, PACKET_BITS each
//   packet_from_output_ports : queue read data per output port (1-cycle read latency)
//   empty                    : queue-empty flags
//   resend                   : downstream stall / replay request
//   outport_sel              : one-hot queue read strobe (combinational)
//   stream_out               : converged packet (registered)
//   upd_drop                 : sticky, a pending update was overwritten before draining
module converge_ctrl_rr #(
  parameter int PACKET_BITS    = 97,
  parameter int NUM_IN_PORTS   = 7,
  parameter int NUM_OUT_PORTS  = 7,
  parameter int UPD_FIFO_DEPTH = 16,
  parameter int UPD_BURST_MAX  = 4
) (
  input  logic                                 clk_bft,
  input  logic                                 reset_bft,
  input  logic [NUM_IN_PORTS-1:0]              freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]  packet_from_input_ports,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] packet_from_output_ports,
  input  logic [NUM_OUT_PORTS-1:0]             empty,
  input  logic                                 resend,
  output logic [NUM_OUT_PORTS-1:0]             outport_sel,
  output logic [PACKET_BITS-1:0]               stream_out,
  output logic                                 upd_drop
);

  localparam int IN_PW   = (NUM_IN_PORTS  > 1) ? $clog2(NUM_IN_PORTS)  : 1;
  localparam int OUT_PW  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int FIFO_AW = $clog2(UPD_FIFO_DEPTH);

  typedef logic [PACKET_BITS-1:0] pkt_t;

  function automatic logic [IN_PW-1:0] in_wrap(input logic [IN_PW-1:0] w);
    if (w == IN_PW'(NUM_IN_PORTS - 1)) return '0;
    return w + IN_PW'(1);
  endfunction

  function automatic logic [OUT_PW-1:0] out_wrap(input logic [OUT_PW-1:0] w);
    if (w == OUT_PW'(NUM_OUT_PORTS - 1)) return '0;
    return w + OUT_PW'(1);
  endfunction

  pkt_t                    slot_q [NUM_IN_PORTS];
  pkt_t                    slot_d [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0] fu_prev_q;
  logic [NUM_IN_PORTS-1:0] rise;
  logic [IN_PW-1:0]        in_ptr_q, in_ptr_d;
  logic [OUT_PW-1:0]       out_ptr_q, out_ptr_d;
  logic                    drop_q, drop_d;

  pkt_t                    fifo_mem [UPD_FIFO_DEPTH];
  logic [FIFO_AW:0]        wr_ptr_q, rd_ptr_q;
  logic                    fifo_empty, fifo_full;

  logic                    drain_vld, drain_wr;
  logic [IN_PW-1:0]        drain_idx;
  pkt_t                    drain_pkt;

  logic                    stall, fifo_rd, data_gnt, force_data;
  logic                    out_vld;
  logic [OUT_PW-1:0]       out_idx;

  logic                    upd_vld_p0;
  pkt_t                    upd_pkt_p0;
  logic [NUM_OUT_PORTS-1:0] sel_p0;
  pkt_t                    arr_pkt;

  logic                    resend_d_q;
  pkt_t                    stream_q, stream_d;
  pkt_t                    hold_q, hold_d;

  assign rise       = freespace_update & ~fu_prev_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  // Full when the addresses match but the wrap bits differ.
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign stall      = resend | resend_d_q;

  // Pick the first pending slot at or after in_ptr, by cyclic distance.
  always_comb begin : drain_pick
    int best;
    int d;
    best      = NUM_IN_PORTS;
    d         = 0;
    drain_vld = 1'b0;
    drain_idx = '0;
    drain_pkt = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      d = (i >= int'(in_ptr_q)) ? (i - int'(in_ptr_q)) : (i + NUM_IN_PORTS - int'(in_ptr_q));
      if (slot_q[i][PACKET_BITS-1] && (d < best)) begin
        best      = d;
        drain_vld = 1'b1;
        drain_idx = IN_PW'(i);
        drain_pkt = slot_q[i];
      end
    end
  end

  assign drain_wr = drain_vld && !fifo_full;
  assign in_ptr_d = drain_wr ? in_wrap(drain_idx) : in_ptr_q;

  // Capture overrides a same-cycle drain; the drained old value is still
  // written, so that case is not counted as a drop.
  always_comb begin : slot_update
    drop_d = drop_q;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      slot_d[i] = slot_q[i];
      if (drain_wr && (drain_idx == IN_PW'(i))) slot_d[i] = '0;
      if (rise[i]) begin
        if (slot_d[i][PACKET_BITS-1]) drop_d = 1'b1;
        slot_d[i] = packet_from_input_ports[i*PACKET_BITS +: PACKET_BITS];
      end
    end
  end

  // First non-empty queue at or after out_ptr.
  always_comb begin : out_pick
    int best;
    int d;
    best    = NUM_OUT_PORTS;
    d       = 0;
    out_vld = 1'b0;
    out_idx = '0;
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      d = (j >= int'(out_ptr_q)) ? (j - int'(out_ptr_q)) : (j + NUM_OUT_PORTS - int'(out_ptr_q));
      if (!empty[j] && (d < best)) begin
        best    = d;
        out_vld = 1'b1;
        out_idx = OUT_PW'(j);
      end
    end
  end

`ifdef CONVERGE_FAIR_EN
  localparam int BURST_W = $clog2(UPD_BURST_MAX + 1);
  logic [BURST_W-1:0] burst_q, burst_d;

  assign force_data = (int'(burst_q) >= UPD_BURST_MAX) && out_vld;

  // Saturates at the limit so a long update-only run cannot wrap it.
  always_comb begin
    burst_d = burst_q;
    if (fifo_empty || data_gnt)                          burst_d = '0;
    else if (fifo_rd && (int'(burst_q) < UPD_BURST_MAX)) burst_d = burst_q + BURST_W'(1);
  end

  always_ff @(posedge clk_bft) begin
    if (reset_bft) burst_q <= '0;
    else           burst_q <= burst_d;
  end
`else
  // The burst limit only has meaning with the fairness option.
  logic unused_burst_max;
  assign unused_burst_max = (UPD_BURST_MAX != 0);
  assign force_data       = 1'b0;
`endif

  always_comb begin : grant
    fifo_rd     = 1'b0;
    data_gnt    = 1'b0;
    outport_sel = '0;
    if (!reset_bft && !stall) begin
      if (!fifo_empty && !force_data) begin
        fifo_rd = 1'b1;
      end else if (out_vld) begin
        data_gnt = 1'b1;
        for (int j = 0; j < NUM_OUT_PORTS; j++)
          outport_sel[j] = (out_idx == OUT_PW'(j));
      end
    end
  end

  assign out_ptr_d = data_gnt ? out_wrap(out_idx) : out_ptr_q;

  // ---- stage p0 -> arrival: FIFO data registered here, queue data arrives from the port ----
  always_comb begin : arrival
    arr_pkt = upd_vld_p0 ? upd_pkt_p0 : '0;
    for (int j = 0; j < NUM_OUT_PORTS; j++)
      if (sel_p0[j]) arr_pkt = arr_pkt | packet_from_output_ports[j*PACKET_BITS +: PACKET_BITS];
  end

  always_comb begin : stream_next
    stream_d = stream_q;
    hold_d   = hold_q;
    unique case ({resend, resend_d_q})
      2'b00: stream_d = arr_pkt;
      2'b10: hold_d   = arr_pkt;
      2'b01: begin
        stream_d = hold_q;
        hold_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_bft) begin
    if (reset_bft) begin
      fu_prev_q  <= '0;
      in_ptr_q   <= '0;
      out_ptr_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_q     <= 1'b0;
      resend_d_q <= 1'b0;
      upd_vld_p0 <= 1'b0;
      sel_p0     <= '0;
      stream_q   <= '0;
      hold_q     <= '0;
      for (int i = 0; i < NUM_IN_PORTS; i++) slot_q[i] <= '0;
    end else begin
      fu_prev_q  <= freespace_update;
      in_ptr_q   <= in_ptr_d;
      out_ptr_q  <= out_ptr_d;
      if (drain_wr) wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
      if (fifo_rd)  rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
      drop_q     <= drop_d;
      resend_d_q <= resend;
      upd_vld_p0 <= fifo_rd;
      sel_p0     <= outport_sel;
      stream_q   <= stream_d;
      hold_q     <= hold_d;
      for (int i = 0; i < NUM_IN_PORTS; i++) slot_q[i] <= slot_d[i];
    end
  end

  // FIFO storage and the p0 read register need no reset; pointers and valids guard them.
  always_ff @(posedge clk_bft) begin
    if (drain_wr) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= drain_pkt;
    if (fifo_rd)  upd_pkt_p0 <= fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
  end

  assign stream_out = stream_q;
  assign upd_drop   = drop_q;

endmodule

// File: tb/tb_converge_ctrl_rr.sv
module tb_converge_ctrl_rr;
  localparam int P     = 97;
  localparam int NI    = 7;
  localparam int NO    = 7;
  localparam int DEPTH = 16;
  localparam int BMAX  = 4;

  typedef logic [P-1:0] pkt_t;

  logic            clk;
  logic            rst;
  logic [NI-1:0]   fu;
  logic [P*NI-1:0] pin;
  logic [P*NO-1:0] pout;
  logic [NO-1:0]   empty_v;
  logic            resend;
  logic [NO-1:0]   sel;
  pkt_t            sout;
  logic            drop;

  pkt_t in_pkt [NI];
  pkt_t rdata  [NO];

  for (genvar g = 0; g < NI; g++) begin : g_in
    assign pin[g*P +: P] = in_pkt[g];
  end
  for (genvar g = 0; g < NO; g++) begin : g_out
    assign pout[g*P +: P] = rdata[g];
  end

  converge_ctrl_rr #(
    .PACKET_BITS(P), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
    .UPD_FIFO_DEPTH(DEPTH), .UPD_BURST_MAX(BMAX)
  ) dut (
    .clk_bft(clk),
    .reset_bft(rst),
    .freespace_update(fu),
    .packet_from_input_ports(pin),
    .packet_from_output_ports(pout),
    .empty(empty_v),
    .resend(resend),
    .outport_sel(sel),
    .stream_out(sout),
    .upd_drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: output-port queues.
  pkt_t oq [NO][$];

  // Reference model state.
  pkt_t    m_slot [NI];
  pkt_t    m_fifo [$];
  int      m_in_ptr, m_out_ptr, m_burst;
  pkt_t    m_arr, m_stream, m_hold;
  bit      m_resd, m_drop;
  logic [NI-1:0] m_prev;

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t rnd_pkt(input bit v);
    logic [127:0] r;
    pkt_t p;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    p = r[P-1:0];
    p[P-1] = v;
    return p;
  endfunction

  task automatic push(input int j, input pkt_t p);
    oq[j].push_back(p);
    empty_v[j] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) m_slot[i] = '0;
    m_fifo.delete();
    m_in_ptr = 0; m_out_ptr = 0; m_burst = 0;
    m_arr = '0; m_stream = '0; m_hold = '0;
    m_resd = 0; m_drop = 0; m_prev = '0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, then let
  // the queues respond to the strobe just after the rising edge.
  task automatic tick();
    logic [NO-1:0] exp_sel, got_sel;
    bit st, gu, gd, full, fair;
    int gj, w, fsz, j, i;
    pkt_t na;
    @(negedge clk);
    got_sel = sel;
    exp_sel = '0; gu = 0; gd = 0; gj = -1; fair = 0;
    st = resend | m_resd;
    if (!rst && !st) begin
      for (int k = 0; k < NO; k++) begin
        j = (m_out_ptr + k) % NO;
        if (gj < 0 && oq[j].size() > 0) gj = j;
      end
`ifdef CONVERGE_FAIR_EN
      fair = (m_burst >= BMAX) && (gj >= 0);
`endif
      if (m_fifo.size() > 0 && !fair) gu = 1;
      else if (gj >= 0) begin
        gd = 1;
        exp_sel[gj] = 1'b1;
      end
    end
    chk("outport_sel", 128'(got_sel), 128'(exp_sel));
    chk("stream_out",  128'(sout),    128'(m_stream));
    chk("upd_drop",    128'(drop),    128'(m_drop));
    if (rst) begin
      model_reset();
    end else begin
      fsz  = m_fifo.size();
      full = (fsz == DEPTH);
      na   = '0;
      if (gu) na = m_fifo.pop_front();
      else if (gd) begin
        na = oq[gj][0];
        m_out_ptr = (gj + 1) % NO;
      end
      case ({resend, m_resd})
        2'b00: m_stream = m_arr;
        2'b10: m_hold   = m_arr;
        2'b01: begin m_stream = m_hold; m_hold = '0; end
        default: ;
      endcase
      m_resd = resend;
      m_arr  = na;
      w = -1;
      for (int k = 0; k < NI; k++) begin
        i = (m_in_ptr + k) % NI;
        if (w < 0 && m_slot[i][P-1]) w = i;
      end
      if (w >= 0 && !full) begin
        m_fifo.push_back(m_slot[w]);
        m_slot[w] = '0;
        m_in_ptr = (w + 1) % NI;
      end
      for (int k = 0; k < NI; k++) begin
        if (fu[k] && !m_prev[k]) begin
          if (m_slot[k][P-1]) m_drop = 1;
          m_slot[k] = in_pkt[k];
        end
      end
      m_prev = fu;
      if (fsz == 0 || gd) m_burst = 0;
      else if (gu && m_burst < BMAX) m_burst++;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NO; k++) begin
      if (got_sel[k]) begin
        if (oq[k].size() > 0) rdata[k] = oq[k].pop_front();
        else rdata[k] = '0;
      end
      empty_v[k] = (oq[k].size() == 0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; fu = '0; resend = 1'b0; empty_v = '1;
    for (int i = 0; i < NI; i++) in_pkt[i] = '0;
    for (int j = 0; j < NO; j++) rdata[j] = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;

    // Queues 0, 2, 5 busy, no updates.
    for (int n = 0; n < 2; n++) begin
      push(0, rnd_pkt(1)); push(2, rnd_pkt(1)); push(5, rnd_pkt(1));
    end
    repeat (8) tick();

    // Simultaneous update edges on in-ports 1 and 3 while queues are busy.
    for (int n = 0; n < 3; n++) begin
      push(0, rnd_pkt(1)); push(2, rnd_pkt(1)); push(5, rnd_pkt(1));
    end
    tick();
    in_pkt[1] = rnd_pkt(1); in_pkt[3] = rnd_pkt(1);
    fu[1] = 1'b1; fu[3] = 1'b1;
    tick();
    fu = '0;
    repeat (10) tick();

    // Captured packet with valid bit clear.
    push(0, rnd_pkt(1)); push(5, rnd_pkt(1));
    in_pkt[2] = rnd_pkt(0);
    fu[2] = 1'b1;
    tick();
    fu[2] = 1'b0;
    repeat (4) tick();

    // Five-cycle resend immediately after a data grant.
    for (int n = 0; n < 3; n++) begin
      push(2, rnd_pkt(1)); push(5, rnd_pkt(1));
    end
    repeat (2) tick();
    resend = 1'b1;
    repeat (5) tick();
    resend = 1'b0;
    repeat (6) tick();

    // Fill FIFO and all slots during a long stall; repeated edges cause drops.
    push(0, rnd_pkt(1)); push(3, rnd_pkt(1));
    resend = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NI; i++) in_pkt[i] = rnd_pkt(1);
      fu = '1;
      tick();
      fu = '0;
      tick();
    end
    repeat (4) tick();
    resend = 1'b0;
    repeat (45) tick();

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      rst    = ($urandom_range(0, 99) == 0);
      resend = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) fu = fu ^ NI'($urandom());
      for (int i = 0; i < NI; i++)
        if ($urandom_range(0, 3) == 0) in_pkt[i] = rnd_pkt($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) begin
        int j;
        j = $urandom_range(0, NO - 1);
        if (oq[j].size() < 8) push(j, rnd_pkt(1));
      end
      tick();
    end
    rst = 1'b0; resend = 1'b0;

    // Update strobe held high through reset counts as an edge afterwards.
    fu = 7'b0000001;
    in_pkt[0] = rnd_pkt(1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();
    fu = '0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
